mrs_shadow_update: RTL and testbench

Parametrised mode-register update engine for the DDR4 controller. Accepts MRS write requests from the testbench/host side, issues them on the command path under bus grant, and enforces tMRD between MRS commands and tMOD before normal traffic. Keeps shadow copies of MR0..MR(NUM_MR-1) and publishes decoded burst length, CL and CWL to the controller. Generalises the earlier single-field BL update to all mode registers, with spacing timers.

---
 rtl/ddr_pkg.sv | 62 ++++++
 rtl/mrs_timer.sv | 25 ++
 rtl/mrs_shadow_update.sv | 146 ++++++++++++++
 tb/tb_mrs_shadow_update.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared types, mode-register reset defaults and field decoders for the DDR4
// mode-register update engine.
package ddr_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        MRD_WAIT = 2'd2
    } mrs_state_e;

    localparam int MR_COUNT_MAX = 8;

    // Power-up images; opcodes wider than 32 bits are not supported.
    localparam logic [31:0] MR_DEFAULT [MR_COUNT_MAX] = '{
        32'h0000_0000,  // MR0: BL8 fixed, CL code 0
        32'h0000_0001,  // MR1: DLL enabled
        32'h0000_0000,  // MR2: CWL code 0
        32'h0000_0000,
        32'h0000_0000,
        32'h0000_0000,
        32'h0000_0000,
        32'h0000_0000
    };

    // A latency decode that may be reserved; valid=0 means keep the old value.
    typedef struct packed {
        logic       valid;
        logic [4:0] value;
    } lat_t;

    function automatic logic [3:0] bl_decode(input logic [1:0] bl_field);
        return (bl_field == 2'b10) ? 4'd4 : 4'd8;
    endfunction

    function automatic lat_t cl_decode(input logic [3:0] code);
        lat_t r;
        r.valid = 1'b1;
        r.value = 5'd0;
        if (code < 4'd8)
            r.value = 5'd9 + 5'(code);
        else if (code < 4'd12)
            r.value = 5'd18 + 5'({code[1:0], 1'b0});
        else
            r.valid = 1'b0;
        return r;
    endfunction

    function automatic lat_t cwl_decode(input logic [2:0] code);
        lat_t r;
        r.valid = 1'b1;
        r.value = 5'd0;
        unique case (code)
            3'd4:    r.value = 5'd14;
            3'd5:    r.value = 5'd16;
            3'd6:    r.value = 5'd18;
            3'd7:    r.valid = 1'b0;
            default: r.value = 5'd9 + 5'(code);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mrs_timer.sv
// Loadable down-counter that stops at zero; used for the tMRD and tMOD spacing.
module mrs_timer #(
    parameter int W = 5
) (
    input  logic         CK_t,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge CK_t) begin
        if (!reset_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mrs_shadow_update.sv
// DDR4 mode-register update engine: issues MRS commands under bus grant, spaces
// them by tMRD/tMOD and publishes BL, CL and CWL decoded from shadow copies.
// Build option MRS_RSVD_CHECK_EN rejects out-of-range MRs and reserved MR0 BL codes.
module mrs_shadow_update
    import ddr_pkg::*;
#(
    parameter int NUM_MR = 7,
    parameter int ADDR_W = 18,
    parameter int TMRD   = 8,
    parameter int TMOD   = 24
) (
    input  logic              CK_t,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_mr,
    input  logic [ADDR_W-1:0] req_data,
    input  logic              bus_gnt,
    output logic              mrs_cmd_valid,
    output logic [1:0]        mrs_cmd_bg,
    output logic [1:0]        mrs_cmd_ba,
    output logic [ADDR_W-1:0] mrs_cmd_addr,
    output logic              mrs_update_rdy,
    output logic [3:0]        burst_len,
    output logic [4:0]        cas_lat,
    output logic [4:0]        cwl,
    output logic              mrs_err
);

    localparam int TW = $clog2(TMOD + 1);

    mrs_state_e        state;
    logic [2:0]        mr_q;
    logic [ADDR_W-1:0] data_q;
    logic [ADDR_W-1:0] shadow [NUM_MR];
    logic              reject;

    logic [TW-1:0]     mrd_count, mod_count;
    logic              mrd_zero, mod_zero, mrd_done;

    logic [3:0]        cl_code;
    logic [2:0]        cwl_code;
    lat_t              cl_dec, cwl_dec;
    logic [4:0]        cl_hold, cwl_hold;

`ifdef MRS_RSVD_CHECK_EN
    assign reject = (int'(req_mr) >= NUM_MR) || (req_mr == 3'd0 && req_data[1:0] == 2'b11);

    always_ff @(posedge CK_t) begin
        if (!reset_n)
            mrs_err <= 1'b0;
        else
            mrs_err <= (state == IDLE) && req_valid && reject;
    end
`else
    assign reject  = 1'b0;
    assign mrs_err = 1'b0;
`endif

    always_ff @(posedge CK_t) begin
        if (!reset_n) begin
            state  <= IDLE;
            mr_q   <= '0;
            data_q <= '0;
        end else begin
            unique case (state)
                IDLE: if (req_valid && !reject) begin
                    mr_q   <= req_mr;
                    data_q <= req_data;
                    state  <= ISSUE;
                end
                ISSUE:    if (bus_gnt)  state <= MRD_WAIT;
                MRD_WAIT: if (mrd_done) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    assign req_ready     = (state == IDLE);
    assign mrs_cmd_valid = (state == ISSUE) && bus_gnt;
    assign mrs_cmd_bg    = mrs_cmd_valid ? {1'b0, mr_q[2]} : 2'b00;
    assign mrs_cmd_ba    = mrs_cmd_valid ? mr_q[1:0] : 2'b00;
    assign mrs_cmd_addr  = mrs_cmd_valid ? data_q : '0;

    // Leave MRD_WAIT as the counter steps onto zero so IDLE lands exactly tMRD after the command.
    assign mrd_done       = mrd_zero || (mrd_count == TW'(1));
    assign mrs_update_rdy = (state == IDLE) && mod_zero;

    mrs_timer #(.W(TW)) u_tmrd (
        .CK_t     (CK_t),
        .reset_n  (reset_n),
        .load     (mrs_cmd_valid),
        .load_val (TW'(TMRD - 1)),
        .count    (mrd_count),
        .zero     (mrd_zero)
    );

    mrs_timer #(.W(TW)) u_tmod (
        .CK_t     (CK_t),
        .reset_n  (reset_n),
        .load     (mrs_cmd_valid),
        .load_val (TW'(TMOD - 1)),
        .count    (mod_count),
        .zero     (mod_zero)
    );

    // NOTE: the shadow array is reset on purpose; decoded latencies must be defined right after reset.
    always_ff @(posedge CK_t) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_MR; i++)
                shadow[i] <= MR_DEFAULT[i][ADDR_W-1:0];
        end else if (mrs_cmd_valid) begin
            for (int i = 0; i < NUM_MR; i++)
                if (mr_q == 3'(i))
                    shadow[i] <= data_q;
        end
    end

    assign cl_code = {shadow[0][6:4], shadow[0][2]};

    generate
        if (NUM_MR > 2) begin : g_mr2
            assign cwl_code = shadow[2][5:3];
        end else begin : g_no_mr2
            assign cwl_code = MR_DEFAULT[2][5:3];
        end
    endgenerate

    assign burst_len = bl_decode(shadow[0][1:0]);
    assign cl_dec    = cl_decode(cl_code);
    assign cwl_dec   = cwl_decode(cwl_code);
    assign cas_lat   = cl_dec.valid  ? cl_dec.value  : cl_hold;
    assign cwl       = cwl_dec.valid ? cwl_dec.value : cwl_hold;

    // Reserved codes fall back to the last legal latency.
    always_ff @(posedge CK_t) begin
        if (!reset_n) begin
            cl_hold  <= 5'd9;
            cwl_hold <= 5'd9;
        end else begin
            cl_hold  <= cas_lat;
            cwl_hold <= cwl;
        end
    end

endmodule

// File: tb/tb_mrs_shadow_update.sv
// Self-checking bench for mrs_shadow_update: directed scenarios plus random traffic
// compared each cycle against a timestamp-based reference model.
module tb_mrs_shadow_update;

    localparam int NUM_MR = 7;
    localparam int ADDR_W = 18;
    localparam int TMRD   = 8;
    localparam int TMOD   = 24;

    logic              CK_t;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_mr;
    logic [ADDR_W-1:0] req_data;
    logic              bus_gnt;
    logic              mrs_cmd_valid;
    logic [1:0]        mrs_cmd_bg;
    logic [1:0]        mrs_cmd_ba;
    logic [ADDR_W-1:0] mrs_cmd_addr;
    logic              mrs_update_rdy;
    logic [3:0]        burst_len;
    logic [4:0]        cas_lat;
    logic [4:0]        cwl;
    logic              mrs_err;

    mrs_shadow_update #(
        .NUM_MR (NUM_MR),
        .ADDR_W (ADDR_W),
        .TMRD   (TMRD),
        .TMOD   (TMOD)
    ) dut (
        .CK_t           (CK_t),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_mr         (req_mr),
        .req_data       (req_data),
        .bus_gnt        (bus_gnt),
        .mrs_cmd_valid  (mrs_cmd_valid),
        .mrs_cmd_bg     (mrs_cmd_bg),
        .mrs_cmd_ba     (mrs_cmd_ba),
        .mrs_cmd_addr   (mrs_cmd_addr),
        .mrs_update_rdy (mrs_update_rdy),
        .burst_len      (burst_len),
        .cas_lat        (cas_lat),
        .cwl            (cwl),
        .mrs_err        (mrs_err)
    );

    initial CK_t = 1'b0;
    always #5 CK_t = ~CK_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Reference model: commands are tracked by the cycle they issued in, not by counters.
    logic [ADDR_W-1:0] m_sh [8];
    bit                m_pending;
    logic [2:0]        m_mr;
    logic [ADDR_W-1:0] m_data;
    int                m_last_cmd;
    int                m_cl, m_cwl;
    bit                m_err;
    bit                m_accepted;

    bit s_cmd, s_rdy, s_upd, s_err;
    int cmd_q[$];

    function automatic int bl_of(input logic [ADDR_W-1:0] mr0);
        return (mr0[1:0] == 2'b10) ? 4 : 8;
    endfunction

    function automatic int cl_of(input logic [ADDR_W-1:0] mr0, input int prev);
        int code = int'(mr0[6:4]) * 2 + int'(mr0[2]);
        if (code < 8)  return 9 + code;
        if (code < 12) return 18 + 2 * (code - 8);
        return prev;
    endfunction

    function automatic int cwl_of(input logic [ADDR_W-1:0] mr2, input int prev);
        int code = int'(mr2[5:3]);
        if (code < 4)  return 9 + code;
        if (code == 4) return 14;
        if (code == 5) return 16;
        if (code == 6) return 18;
        return prev;
    endfunction

    function automatic bit rejected(input logic [2:0] mr, input logic [ADDR_W-1:0] d);
`ifdef MRS_RSVD_CHECK_EN
        return (int'(mr) >= NUM_MR) || (mr == 3'd0 && d[1:0] == 2'b11);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_sh[i] = '0;
        m_pending  = 1'b0;
        m_mr       = '0;
        m_data     = '0;
        m_last_cmd = -1000;
        m_cl       = 9;
        m_cwl      = 9;
        m_err      = 1'b0;
    endtask

    // One clock: apply inputs, compare every output at the falling edge, advance the model.
    task automatic step(input bit v, input logic [2:0] mr, input logic [ADDR_W-1:0] d,
                        input bit g, input bit rn);
        bit idle, cmd;
        req_valid = v;
        req_mr    = mr;
        req_data  = d;
        bus_gnt   = g;
        reset_n   = rn;
        @(negedge CK_t);
        idle = !m_pending && (cyc >= m_last_cmd + TMRD);
        cmd  = m_pending && g;
        check("req_ready",      req_ready,      idle);
        check("mrs_cmd_valid",  mrs_cmd_valid,  cmd);
        check("mrs_cmd_bg",     mrs_cmd_bg,     cmd ? {1'b0, m_mr[2]} : 2'b00);
        check("mrs_cmd_ba",     mrs_cmd_ba,     cmd ? m_mr[1:0] : 2'b00);
        check("mrs_cmd_addr",   mrs_cmd_addr,   cmd ? m_data : '0);
        check("mrs_update_rdy", mrs_update_rdy, idle && (cyc >= m_last_cmd + TMOD));
        check("burst_len",      burst_len,      bl_of(m_sh[0]));
        check("cas_lat",        cas_lat,        m_cl);
        check("cwl",            cwl,            m_cwl);
        check("mrs_err",        mrs_err,        m_err);
        s_cmd = mrs_cmd_valid;
        s_rdy = req_ready;
        s_upd = mrs_update_rdy;
        s_err = mrs_err;
        if (s_cmd) cmd_q.push_back(cyc);

        m_accepted = 1'b0;
        if (!rn) begin
            model_reset();
        end else begin
            m_err = 1'b0;
            if (cmd) begin
                if (int'(m_mr) < NUM_MR) begin
                    m_sh[m_mr] = m_data;
                    if (m_mr == 3'd0) m_cl  = cl_of(m_data, m_cl);
                    if (m_mr == 3'd2) m_cwl = cwl_of(m_data, m_cwl);
                end
                m_last_cmd = cyc;
                m_pending  = 1'b0;
            end else if (idle && v) begin
                m_accepted = 1'b1;
                if (rejected(mr, d)) begin
                    m_err = 1'b1;
                end else begin
                    m_pending = 1'b1;
                    m_mr      = mr;
                    m_data    = d;
                end
            end
        end
        @(posedge CK_t);
        #1;
        cyc++;
    endtask

    task automatic idle_cycles(input int k, input bit g);
        for (int i = 0; i < k; i++) step(1'b0, 3'd0, '0, g, 1'b1);
    endtask

    // Holds a request until the model says it was taken; returns the accepting cycle.
    task automatic send(input logic [2:0] mr, input logic [ADDR_W-1:0] d, input bit g,
                        output int acc_cyc);
        acc_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, mr, d, g, 1'b1);
            if (m_accepted) begin
                acc_cyc = cyc - 1;
                break;
            end
        end
        check("accept_timeout", m_accepted, 1'b1);
    endtask

    // Idles k cycles and records the first cycle each ready flag is seen high.
    int first_rdy, first_upd;
    task automatic watch(input int k, input bit g);
        first_rdy = -1;
        first_upd = -1;
        for (int i = 0; i < k; i++) begin
            step(1'b0, 3'd0, '0, g, 1'b1);
            if (s_rdy && first_rdy < 0) first_rdy = cyc - 1;
            if (s_upd && first_upd < 0) first_upd = cyc - 1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int errs_seen;

        req_valid = 1'b0;
        req_mr    = '0;
        req_data  = '0;
        bus_gnt   = 1'b0;
        reset_n   = 1'b0;
        repeat (2) @(posedge CK_t);
        #1;
        model_reset();

        // Reset state
        check("rst_req_ready",   req_ready,      1'b1);
        check("rst_update_rdy",  mrs_update_rdy, 1'b1);
        check("rst_cmd_valid",   mrs_cmd_valid,  1'b0);
        check("rst_burst_len",   burst_len,      4'd8);
        check("rst_cas_lat",     cas_lat,        5'd9);
        check("rst_cwl",         cwl,            5'd9);
        check("rst_mrs_err",     mrs_err,        1'b0);

        // MR0 BL4 with grant tied high
        cmd_q.delete();
        send(3'd0, 18'h00002, 1'b1, t);
        watch(30, 1'b1);
        check("bl4_cmd_cycle",   cmd_q.size() > 0 ? cmd_q[0] : -1, t + 1);
        check("bl4_ready_cycle", first_rdy, t + 1 + TMRD);
        check("bl4_tmod_cycle",  first_upd, t + 1 + TMOD);
        check("bl4_burst_len",   burst_len, 4'd4);

        // MR2 CWL code 4 with grant withheld for five cycles
        cmd_q.delete();
        send(3'd2, 18'h00020, 1'b0, t);
        idle_cycles(5, 1'b0);
        watch(30, 1'b1);
        check("cwl_cmd_cycle",   cmd_q.size() > 0 ? cmd_q[0] : -1, t + 6);
        check("cwl14",           cwl, 5'd14);

        // Legal CL16, then a reserved CL code that must keep it, then MR1 back-to-back
        send(3'd0, 18'h00034, 1'b1, t);
        watch(30, 1'b1);
        check("cl16",            cas_lat, 5'd16);
        cmd_q.delete();
        send(3'd0, 18'h00070, 1'b1, t);
        send(3'd1, 18'h00401, 1'b1, t);
        watch(40, 1'b1);
        check("b2b_cmd_count",   cmd_q.size(), 2);
        if (cmd_q.size() == 2) begin
            check("b2b_spacing",    cmd_q[1] - cmd_q[0], TMRD + 1);
            check("b2b_tmod_cycle", first_upd, cmd_q[1] + TMOD);
        end
        check("cl_hold",         cas_lat, 5'd16);

        // Reserved BL code
        cmd_q.delete();
        errs_seen = 0;
        send(3'd0, 18'h00003, 1'b1, t);
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 3'd0, '0, 1'b1, 1'b1);
            if (s_err) errs_seen++;
        end
`ifdef MRS_RSVD_CHECK_EN
        check("rsvd_cmd_count",  cmd_q.size(), 0);
        check("rsvd_err_pulses", errs_seen, 1);
`else
        check("rsvd_cmd_count",  cmd_q.size(), 1);
        check("rsvd_err_pulses", errs_seen, 0);
`endif
        check("rsvd_burst_len",  burst_len, 4'd8);

        // Reset while waiting out tMRD
        send(3'd0, 18'h00002, 1'b1, t);
        idle_cycles(3, 1'b1);
        step(1'b0, 3'd0, '0, 1'b1, 1'b0);
        check("midrst_ready",      req_ready,      1'b1);
        check("midrst_update_rdy", mrs_update_rdy, 1'b1);
        check("midrst_burst_len",  burst_len,      4'd8);
        check("midrst_cas_lat",    cas_lat,        5'd9);
        idle_cycles(5, 1'b1);

        // Random traffic
        for (int i = 0; i < 900; i++) begin
            logic [ADDR_W-1:0] d;
            d = ADDR_W'($urandom);
            step($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), d,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 99) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
